// File: rtl/proj_param_pkg.sv
// proj_param_pkg: project-wide sizing parameters shared across pad blocks
package proj_param_pkg;
    localparam int PROJ_GPIO = 4;
endpackage

// File: rtl/verilab_pads_pkg.sv
// verilab_pads_pkg: shared defaults and edge-type enum for the pad input blocks
package verilab_pads_pkg;
    localparam int DEBOUNCE_W_DEF = 8;
    typedef enum logic [1:0] {NONE, RISE, FALL} edge_t;
endpackage

// File: rtl/verilab_pads_debounce_bit.sv
// verilab_pads_debounce_bit: one pad bit -- 2-flop sync, optional debounce, edge pulses
// Debounce counter present only when VERILAB_PADS_GPIO_IN_DEBOUNCE_EN is defined.
import verilab_pads_pkg::*;
module verilab_pads_debounce_bit #(
    parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pad,
    input  logic [DEBOUNCE_W-1:0] n,
    output logic                  stable,
    output logic                  rise,
    output logic                  fall
);
    logic  sync1, sync2, upd;
    edge_t ev;
    always_ff @(posedge clk or posedge rst)
        if (rst) {sync2, sync1} <= '0;
        else     {sync2, sync1} <= {sync1, pad};
`ifdef VERILAB_PADS_GPIO_IN_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt;
    // >= lets a threshold lowered mid-count take effect on the next compare
    assign upd = (sync2 != stable) && (cnt >= n);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= (sync2 == stable || upd) ? '0 : cnt + 1'b1;
`else
    logic unused_n;
    assign unused_n = ^n;
    assign upd = sync2 != stable;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst)      stable <= 1'b0;
        else if (upd) stable <= sync2;
    always_comb ev = upd ? (sync2 ? RISE : FALL) : NONE;
    assign rise = ev == RISE;
    assign fall = ev == FALL;
endmodule

// File: rtl/verilab_pads_gpio_in.sv
// verilab_pads_gpio_in: debounced GPIO inputs with sticky edge interrupt status
// Debounce enabled by VERILAB_PADS_GPIO_IN_DEBOUNCE_EN; otherwise debounce_cnt is ignored.
import verilab_pads_pkg::*;
module verilab_pads_gpio_in #(
    parameter int GPIO       = proj_param_pkg::PROJ_GPIO,
    parameter int DEBOUNCE_W = DEBOUNCE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO-1:0]       pad_in,
    input  logic [DEBOUNCE_W-1:0] debounce_cnt,
    input  logic [GPIO-1:0]       rise_en,
    input  logic [GPIO-1:0]       fall_en,
    input  logic [GPIO-1:0]       irq_clr,
    output logic [GPIO-1:0]       gpio_val,
    output logic [GPIO-1:0]       irq_status,
    output logic                  irq
);
    logic [GPIO-1:0] rise, fall, set;
    for (genvar i = 0; i < GPIO; i++) begin : g_bit
        verilab_pads_debounce_bit #(.DEBOUNCE_W(DEBOUNCE_W)) u_bit (
            .clk(clk),
            .rst(rst),
            .pad(pad_in[i]),
            .n(debounce_cnt),
            .stable(gpio_val[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end
    assign set = (rise & rise_en) | (fall & fall_en);
    // set wins over a same-cycle clear so no event is lost
    always_ff @(posedge clk or posedge rst)
        if (rst) irq_status <= '0;
        else     irq_status <= (irq_status & ~irq_clr) | set;
    assign irq = |irq_status;
endmodule

// File: tb/tb_verilab_pads_gpio_in.sv
// tb_verilab_pads_gpio_in: directed scoreboard bench; expectations follow the debounce macro
module tb_verilab_pads_gpio_in;
    localparam int G = proj_param_pkg::PROJ_GPIO;
`ifdef VERILAB_PADS_GPIO_IN_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    typedef struct {
        int          at;
        string       tag;
        logic [G-1:0] gv;
        logic [G-1:0] st;
        logic        iq;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic [G-1:0] pad_in = '0, rise_en = '0, fall_en = '0, irq_clr = '0;
    logic [7:0]   debounce_cnt = '0;
    logic [G-1:0] gpio_val, irq_status;
    logic         irq;
    int           cyc = 0, checks = 0, errors = 0, t;
    exp_t         sb[$];

    verilab_pads_gpio_in dut (
        .clk(clk), .rst(rst), .pad_in(pad_in), .debounce_cnt(debounce_cnt),
        .rise_en(rise_en), .fall_en(fall_en), .irq_clr(irq_clr),
        .gpio_val(gpio_val), .irq_status(irq_status), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int n);
        return 3 + (DEB ? n : 0);
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(int at, string tag, logic [G-1:0] gv, logic [G-1:0] st);
        exp_t e;
        e.at = at; e.tag = tag; e.gv = gv; e.st = st; e.iq = |st;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.at == cyc && gpio_val === e.gv && irq_status === e.st && irq === e.iq)
            else begin
                errors++;
                $error("FAIL %s @%0d: gpio_val=%b irq_status=%b irq=%b expected gpio_val=%b irq_status=%b irq=%b at %0d",
                       e.tag, cyc, gpio_val, irq_status, irq, e.gv, e.st, e.iq, e.at);
            end
        end
    end

    initial begin
        tick(3);
        push(cyc + 1, "reset", 4'b0000, 4'b0000);
        tick(2);
        rst = 1'b0;
        // basic rise with N=0
        debounce_cnt = 8'd0; rise_en = 4'b0001; t = cyc;
        pad_in = 4'b0001;
        push(t + 2, "a_pre", 4'b0000, 4'b0000);
        push(t + 3, "a_rise", 4'b0001, 4'b0001);
        tick(4);
        irq_clr = 4'b0001;
        push(cyc + 1, "a_clr", 4'b0001, 4'b0000);
        tick(1);
        irq_clr = '0;
        // glitch of 3 cycles with N=4
        debounce_cnt = 8'd4; rise_en = 4'b0011; t = cyc;
        pad_in = 4'b0011;
        if (DEB) begin
            push(t + 3, "b_gl3", 4'b0001, 4'b0000);
            push(t + 6, "b_gl6", 4'b0001, 4'b0000);
            push(t + 9, "b_gl9", 4'b0001, 4'b0000);
        end else begin
            push(t + 3, "b_gl3", 4'b0011, 4'b0010);
            push(t + 6, "b_gl6", 4'b0001, 4'b0010);
        end
        tick(3);
        pad_in = 4'b0001;
        tick(7);
        irq_clr = 4'b1111;
        push(cyc + 1, "b_clr", 4'b0001, 4'b0000);
        tick(1);
        irq_clr = '0;
        // held pulse with N=4
        t = cyc;
        pad_in = 4'b0011;
        push(t + lat(4) - 1, "b_pre", 4'b0001, 4'b0000);
        push(t + lat(4), "b_rise", 4'b0011, 4'b0010);
        tick(lat(4) + 1);
        // fall with fall_en off sets no status
        t = cyc;
        pad_in = 4'b0001;
        push(t + lat(4), "b_fall_dis", 4'b0001, 4'b0010);
        tick(lat(4) + 1);
        irq_clr = 4'b0010;
        push(cyc + 1, "b_clr2", 4'b0001, 4'b0000);
        tick(1);
        irq_clr = '0;
        // set-wins and disable-keeps-status on bit 2
        rise_en = 4'b0100; fall_en = 4'b0100; t = cyc;
        pad_in = 4'b0101;
        push(t + lat(4), "c_rise", 4'b0101, 4'b0100);
        tick(lat(4));
        rise_en = 4'b0000;
        push(cyc + 2, "c_disable", 4'b0101, 4'b0100);
        tick(3);
        t = cyc;
        pad_in = 4'b0001;
        tick(lat(4) - 1);
        irq_clr = 4'b0100;
        push(t + lat(4), "c_setwins", 4'b0001, 4'b0100);
        tick(1);
        irq_clr = '0;
        push(cyc + 1, "c_hold", 4'b0001, 4'b0100);
        tick(1);
        irq_clr = 4'b0100;
        push(cyc + 1, "c_clr", 4'b0001, 4'b0000);
        tick(1);
        irq_clr = '0; fall_en = '0;
        // maximum threshold without wrap
        debounce_cnt = 8'd255; rise_en = 4'b1000; t = cyc;
        pad_in = 4'b1001;
        push(t + lat(255) - 1, "d_pre", 4'b0001, 4'b0000);
        push(t + lat(255), "d_rise", 4'b1001, 4'b1000);
        push(t + 300, "d_hold", 4'b1001, 4'b1000);
        tick(301);
        // reset mid-count, pads held high through release
        debounce_cnt = 8'd2; rise_en = 4'b1111;
        pad_in = 4'b1111;
        tick(DEB ? 3 : 2);
        rst = 1'b1;
        push(cyc + 1, "e_reset", 4'b0000, 4'b0000);
        tick(3);
        rst = 1'b0; t = cyc;
        push(t + lat(2) - 1, "e_pre", 4'b0000, 4'b0000);
        push(t + lat(2), "e_rise", 4'b1111, 4'b1111);
        tick(lat(2) + 2);
        // one-cycle pulse with N=10
        debounce_cnt = 8'd10; fall_en = 4'b1111;
        irq_clr = 4'b1111;
        push(cyc + 1, "f_clr", 4'b1111, 4'b0000);
        tick(1);
        irq_clr = '0; t = cyc;
        pad_in = 4'b1110;
        if (DEB) begin
            push(t + 3, "f_glitch", 4'b1111, 4'b0000);
            push(t + 14, "f_glitch_late", 4'b1111, 4'b0000);
        end else begin
            push(t + 3, "f_pulse", 4'b1110, 4'b0001);
            push(t + 4, "f_back", 4'b1111, 4'b0001);
        end
        tick(1);
        pad_in = 4'b1111;
        tick(16);
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/verilab_pads_gpio_in.md
VERILAB_PADS_GPIO_IN -- requirements
Module: verilab_pads_gpio_in

Interface
REQ-001 Parameter GPIO, default proj_param_pkg::PROJ_GPIO, number of pad input bits.
REQ-002 Parameter DEBOUNCE_W, default 8, width of the debounce threshold and of each per-bit counter.
REQ-003 clk  input  1  single block clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pad_in  input  GPIO  raw asynchronous pad levels.
REQ-006 debounce_cnt  input  DEBOUNCE_W  stability threshold N, quasi-static.
REQ-007 rise_en  input  GPIO  per-bit rising-edge interrupt enable.
REQ-008 fall_en  input  GPIO  per-bit falling-edge interrupt enable.
REQ-009 irq_clr  input  GPIO  per-bit write-1-to-clear pulse for irq_status.
REQ-010 gpio_val  output  GPIO  debounced stable level per bit.
REQ-011 irq_status  output  GPIO  sticky per-bit edge status.
REQ-012 irq  output  1  OR-reduction of irq_status.

Function
REQ-013 Each pad_in bit SHALL pass a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Per bit: counter SHALL clear whenever sync2 == stable.
REQ-015 Per bit: while sync2 != stable and counter < N, counter SHALL increment by 1 each cycle.
REQ-016 Per bit: when sync2 != stable and counter == N, stable SHALL take sync2 and counter SHALL clear in that cycle.
REQ-017 Latency: pad_in change settled before edge 1 and held SHALL appear on gpio_val at edge 3+N; N=0 gives 3 cycles.
REQ-018 Glitch: a mismatch lasting fewer than N+1 consecutive sync2 cycles SHALL leave gpio_val unchanged and the counter cleared.
REQ-019 The counter SHALL never exceed N; N = 2^DEBOUNCE_W-1 SHALL be legal without wrap-around.
REQ-020 A 0->1 stable update with rise_en=1, or 1->0 with fall_en=1, SHALL set the irq_status bit on the same edge gpio_val updates.
REQ-021 irq_clr bit =1 SHALL clear the irq_status bit on the next edge.
REQ-022 Simultaneous set and clear on one bit SHALL leave the bit set (set wins).
REQ-023 Disabling rise_en/fall_en SHALL NOT clear an already-set status bit.
REQ-024 irq SHALL be combinational |irq_status, no added latency.
REQ-025 A change of debounce_cnt mid-count SHALL take effect on the next compare; no other recovery is required.

Reset
REQ-026 On rst: sync1, sync2, stable, counters, gpio_val, irq_status SHALL be 0, and irq SHALL be 0.
REQ-027 A pad held 1 through reset release SHALL be treated as a genuine rising edge after 3+N cycles.
REQ-028 rst asserted mid-count SHALL abandon the count; no status SHALL be set from pre-reset activity.

Configuration
REQ-029 Macro VERILAB_PADS_GPIO_IN_DEBOUNCE_EN defined: debounce counters are present as in REQ-014..019.
REQ-030 Macro absent: no counters; stable SHALL take sync2 every cycle, identical to N=0; debounce_cnt is ignored.

Structure
REQ-031 GPIO default comes from proj_param_pkg; DEBOUNCE_W default and the edge-type enum (NONE, RISE, FALL) SHALL live in package verilab_pads_pkg.
REQ-032 Per-bit synchronizer, debounce and edge detect SHALL be sub-module verilab_pads_debounce_bit, instantiated GPIO times via generate.
REQ-033 verilab_pads_debounce_bit outputs stable plus single-cycle rise/fall pulses; sticky status logic SHALL stay in the top.

Verification
REQ-034 N=0, rise_en[0]=1, pad_in[0] 0->1 → gpio_val[0]=1 and irq_status[0]=1 at edge 3, irq=1.
REQ-035 N=4, pad_in[1] high for 3 cycles then low → gpio_val[1] stays 0, no status; high for 5 cycles → gpio_val[1]=1 at edge 7.
REQ-036 irq_status[2]=1, irq_clr[2] pulsed on the same edge a new fall event occurs with fall_en[2]=1 → bit remains 1.
REQ-037 pad_in=all ones through reset, rise_en=all ones, N=2 → all irq_status bits set at edge 5 after release.
REQ-038 N=255 (DEBOUNCE_W=8), pad change held 300 cycles → update at edge 258, counter never wraps.
REQ-039 Build without VERILAB_PADS_GPIO_IN_DEBOUNCE_EN, N=10 → 1-cycle pad pulse reaches gpio_val at edge 3.
